// File: rtl/muldiv_pkg.sv
// muldiv_pkg
// Shared definitions for the execute-stage multiply/divide unit: the funct
// codes it shares with ALU_32, the sequencer state encoding and the default
// datapath width.
// Ports: none (package).
package muldiv_pkg;

    localparam int MULDIV_WIDTH = 32;

    localparam logic [5:0] FUNCT_ADD   = 6'd32;
    localparam logic [5:0] FUNCT_SUB   = 6'd34;
    localparam logic [5:0] FUNCT_AND   = 6'd36;
    localparam logic [5:0] FUNCT_OR    = 6'd37;
    localparam logic [5:0] FUNCT_SLT   = 6'd42;
    localparam logic [5:0] FUNCT_MFHI  = 6'd16;
    localparam logic [5:0] FUNCT_MFLO  = 6'd18;
    localparam logic [5:0] FUNCT_MULT  = 6'd24;
    localparam logic [5:0] FUNCT_MULTU = 6'd25;
    localparam logic [5:0] FUNCT_DIV   = 6'd26;
    localparam logic [5:0] FUNCT_DIVU  = 6'd27;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/divu_step.sv
// divu_step
// One combinational step of unsigned restoring division. The partial
// remainder is shifted left with the next dividend bit; if the divisor fits,
// it is subtracted and the quotient bit is 1, otherwise the shifted value is
// kept and the quotient bit is 0.
// Ports:
//   rem_i      current partial remainder (always < divisor)
//   bit_i      next dividend bit, MSB first
//   divisor_i  divisor
//   rem_o      next partial remainder
//   qbit_o     quotient bit produced by this step
module divu_step
    import muldiv_pkg::*;
#(
    parameter int WIDTH = MULDIV_WIDTH
) (
    input  logic [WIDTH-1:0] rem_i,
    input  logic             bit_i,
    input  logic [WIDTH-1:0] divisor_i,
    output logic [WIDTH-1:0] rem_o,
    output logic             qbit_o
);

    logic [WIDTH:0]   shifted;
    logic [WIDTH-1:0] diffLow;

    assign shifted = {rem_i, bit_i};

    // When the divisor fits, the true difference is below the divisor and
    // therefore fits in WIDTH bits, so the low bits of the subtraction suffice.
    assign diffLow = shifted[WIDTH-1:0] - divisor_i;
    assign qbit_o  = (shifted >= {1'b0, divisor_i});
    assign rem_o   = qbit_o ? diffLow : shifted[WIDTH-1:0];

endmodule

// File: rtl/muldiv_hilo.sv
// muldiv_hilo
// Multi-cycle multiply/divide unit beside ALU_32. It owns the HI/LO pair,
// runs shift-add multiply or restoring divide at one bit per clock, and
// serves MFHI/MFLO reads through dataout_o.
// Optional feature: define SIGNED_MULDIV_EN to add MULT/DIV (signed); when
// undefined, funct 24 and 26 are ignored like any unsupported code.
// Ports:
//   clk_i      rising-edge clock
//   reset_i    synchronous active-high reset, aborts any operation
//   start_i    request, sampled only in IDLE
//   sel_i      6-bit funct code
//   a_i, b_i   multiplicand/dividend and multiplier/divisor
//   busy_o     high while iterating
//   done_o     one-cycle completion pulse
//   hi_o, lo_o HI and LO registers
//   dataout_o  HI for MFHI, LO for MFLO, otherwise 0
module muldiv_hilo
    import muldiv_pkg::*;
#(
    parameter int WIDTH = MULDIV_WIDTH,
    parameter int CNT_W = 6
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             start_i,
    input  logic [5:0]       sel_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o,
    output logic [WIDTH-1:0] dataout_o
);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    // acc_q: multiply accumulator P (with carry bit) or division remainder.
    // low_q: multiplier being shifted out, or dividend shifting into quotient.
    // opb_q: multiplicand or divisor.
    logic [WIDTH:0]   acc_q, acc_d;
    logic [WIDTH-1:0] low_q, low_d;
    logic [WIDTH-1:0] opb_q, opb_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic             isDiv_q, isDiv_d;
    logic             negRes_q, negRes_d;
    logic             negRem_q, negRem_d;

    logic             acceptMul, acceptDiv, acceptSigned;
    logic             signA, signB;
    logic [WIDTH-1:0] magA, magB;

    logic [WIDTH:0]     mulSum;
    logic [WIDTH:0]     mulAccNext;
    logic [WIDTH-1:0]   mulLowNext;
    logic [2*WIDTH-1:0] product, prodRes;
    logic [WIDTH-1:0]   divRem, divLowNext, quoRes, remRes;
    logic               divQbit;

    // Decode which operation the current funct code would start.
    always_comb begin
        acceptMul    = 1'b0;
        acceptDiv    = 1'b0;
        acceptSigned = 1'b0;
        if (sel_i == FUNCT_MULTU) acceptMul = 1'b1;
        if (sel_i == FUNCT_DIVU)  acceptDiv = 1'b1;
`ifdef SIGNED_MULDIV_EN
        if (sel_i == FUNCT_MULT) begin
            acceptMul    = 1'b1;
            acceptSigned = 1'b1;
        end
        if (sel_i == FUNCT_DIV) begin
            acceptDiv    = 1'b1;
            acceptSigned = 1'b1;
        end
`endif
    end

    // Signed operations iterate on magnitudes; the signs are remembered and
    // applied to the result at the completion write.
    assign signA = acceptSigned & a_i[WIDTH-1];
    assign signB = acceptSigned & b_i[WIDTH-1];
    assign magA  = signA ? -a_i : a_i;
    assign magB  = signB ? -b_i : b_i;

    // Shift-add multiply step: add the multiplicand when the multiplier LSB
    // is set, then shift {P, multiplier} right by one. The carry lands in
    // P's extra bit, so nothing is lost.
    assign mulSum     = acc_q + (low_q[0] ? {1'b0, opb_q} : {(WIDTH+1){1'b0}});
    assign mulAccNext = {1'b0, mulSum[WIDTH:1]};
    assign mulLowNext = {mulSum[0], low_q[WIDTH-1:1]};
    assign product    = {mulAccNext[WIDTH-1:0], mulLowNext};
    assign prodRes    = negRes_q ? -product : product;

    divu_step #(.WIDTH(WIDTH)) u_divu_step (
        .rem_i     (acc_q[WIDTH-1:0]),
        .bit_i     (low_q[WIDTH-1]),
        .divisor_i (opb_q),
        .rem_o     (divRem),
        .qbit_o    (divQbit)
    );

    assign divLowNext = {low_q[WIDTH-2:0], divQbit};
    // Quotient truncates toward zero; the remainder follows the dividend sign.
    assign quoRes     = negRes_q ? -divLowNext : divLowNext;
    assign remRes     = negRem_q ? -divRem : divRem;

    // Sequencer next-state and datapath updates. The final RUN edge writes
    // HI/LO from this cycle's step result so that DONE already shows them.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        low_d    = low_q;
        opb_d    = opb_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        isDiv_d  = isDiv_q;
        negRes_d = negRes_q;
        negRem_d = negRem_q;
        case (state_q)
            IDLE: begin
                if (start_i && (acceptMul || acceptDiv)) begin
                    cnt_d    = '0;
                    acc_d    = '0;
                    isDiv_d  = acceptDiv;
                    negRes_d = signA ^ signB;
                    negRem_d = signA;
                    if (acceptDiv) begin
                        low_d = magA;
                        opb_d = magB;
                    end else begin
                        low_d = magB;
                        opb_d = magA;
                    end
                    if (acceptDiv && (b_i == '0)) begin
                        hi_d    = a_i;
                        lo_d    = '1;
                        state_d = DONE;
                    end else begin
                        state_d = RUN;
                    end
                end
            end
            RUN: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (isDiv_q) begin
                    acc_d = {1'b0, divRem};
                    low_d = divLowNext;
                end else begin
                    acc_d = mulAccNext;
                    low_d = mulLowNext;
                end
                if (cnt_q == CNT_W'(WIDTH-1)) begin
                    state_d = DONE;
                    if (isDiv_q) begin
                        hi_d = remRes;
                        lo_d = quoRes;
                    end else begin
                        hi_d = prodRes[2*WIDTH-1:WIDTH];
                        lo_d = prodRes[WIDTH-1:0];
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers; reset clears everything and abandons any
    // operation in flight.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            acc_q    <= '0;
            low_q    <= '0;
            opb_q    <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            isDiv_q  <= 1'b0;
            negRes_q <= 1'b0;
            negRem_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            low_q    <= low_d;
            opb_q    <= opb_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            isDiv_q  <= isDiv_d;
            negRes_q <= negRes_d;
            negRem_q <= negRem_d;
        end
    end

    // MFHI/MFLO read path, merged with the ALU result downstream.
    always_comb begin
        dataout_o = '0;
        if (sel_i == FUNCT_MFHI) begin
            dataout_o = hi_q;
        end else if (sel_i == FUNCT_MFLO) begin
            dataout_o = lo_q;
        end
    end

    assign busy_o = (state_q == RUN);
    assign done_o = (state_q == DONE);
    assign hi_o   = hi_q;
    assign lo_o   = lo_q;

endmodule

// File: tb/tb_muldiv_hilo.sv
// tb_muldiv_hilo
// Self-checking bench for muldiv_hilo. Expected HI/LO come from a plain
// arithmetic model of multiply/divide; timing expectations come from the
// documented cycle numbering (start in cycle 0, done in cycle 33 or 1).
module tb_muldiv_hilo;

    localparam logic [5:0] SEL_MULTU = 6'd25;
    localparam logic [5:0] SEL_DIVU  = 6'd27;
    localparam logic [5:0] SEL_MULT  = 6'd24;
    localparam logic [5:0] SEL_DIV   = 6'd26;
    localparam logic [5:0] SEL_MFHI  = 6'd16;
    localparam logic [5:0] SEL_MFLO  = 6'd18;
    localparam logic [5:0] SEL_ADD   = 6'd32;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [5:0]  sel;
    logic [31:0] a, b;
    logic        busy, done;
    logic [31:0] hi, lo, dataout;

    int checks = 0;
    int errors = 0;
    logic [31:0] expHi, expLo;

    always #5 clk = ~clk;

    muldiv_hilo dut (
        .clk_i     (clk),
        .reset_i   (reset),
        .start_i   (start),
        .sel_i     (sel),
        .a_i       (a),
        .b_i       (b),
        .busy_o    (busy),
        .done_o    (done),
        .hi_o      (hi),
        .lo_o      (lo),
        .dataout_o (dataout)
    );

    // Reference model: HI/LO that the instruction architecturally produces.
    function automatic void refModel(input logic [5:0] s, input logic [31:0] x,
                                     input logic [31:0] y,
                                     output logic [31:0] eh, output logic [31:0] el);
        logic [63:0] p;
        longint q, r;
        eh = '0; el = '0; p = '0; q = 0; r = 0;
        case (s)
            SEL_MULTU: begin
                p = {32'd0, x} * {32'd0, y};
                eh = p[63:32]; el = p[31:0];
            end
            SEL_MULT: begin
                p = longint'($signed(x)) * longint'($signed(y));
                eh = p[63:32]; el = p[31:0];
            end
            SEL_DIVU: begin
                if (y == 0) begin eh = x; el = '1; end
                else begin el = x / y; eh = x % y; end
            end
            SEL_DIV: begin
                if (y == 0) begin eh = x; el = '1; end
                else begin
                    q = longint'($signed(x)) / longint'($signed(y));
                    r = longint'($signed(x)) % longint'($signed(y));
                    el = q[31:0]; eh = r[31:0];
                end
            end
            default: ;
        endcase
    endfunction

    // Drive start for exactly cycle 0, then scramble the operands; returns
    // shortly after the edge that begins cycle 1.
    task automatic startOp(input logic [5:0] s, input logic [31:0] x, input logic [31:0] y);
        @(posedge clk); #1;
        start = 1'b1; sel = s; a = x; b = y;
        @(posedge clk); #1;
        start = 1'b0; a = $urandom; b = $urandom; sel = SEL_ADD;
    endtask

    // Watch cycles 1..limit; report the cycle in which done appears (-1 if
    // never) and how many busy cycles were seen up to it.
    task automatic observe(input int limit, output int doneCycle, output int busyCount);
        doneCycle = -1;
        busyCount = 0;
        for (int c = 1; c <= limit; c++) begin
            @(negedge clk);
            if (busy) busyCount++;
            if (done) begin
                doneCycle = c;
                break;
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b1; sel = SEL_MULTU; a = 32'd3; b = 32'd4;
        repeat (3) @(posedge clk);
        #1 sel = SEL_MFHI;
        @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("[TB] FAIL reset_done: got %b expected 0", done); end
        checks++; if (hi !== 32'd0) begin errors++; $display("[TB] FAIL reset_hi: got %h expected 0", hi); end
        checks++; if (lo !== 32'd0) begin errors++; $display("[TB] FAIL reset_lo: got %h expected 0", lo); end
        checks++; if (dataout !== 32'd0) begin errors++; $display("[TB] FAIL reset_dataout: got %h expected 0", dataout); end
        start = 1'b0;
        @(posedge clk); #1 reset = 1'b0;
        @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_release_busy: got %b expected 0", busy); end
        expHi = '0; expLo = '0;
    endtask

    task automatic test_multu();
        int dc, bc;
        startOp(SEL_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        observe(40, dc, bc);
        refModel(SEL_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, expHi, expLo);
        checks++; if (dc !== 33) begin errors++; $display("[TB] FAIL multu_done_cycle: got %0d expected 33", dc); end
        checks++; if (bc !== 32) begin errors++; $display("[TB] FAIL multu_busy_cycles: got %0d expected 32", bc); end
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL multu_busy_in_done: got %b expected 0", busy); end
        checks++; if (hi !== expHi) begin errors++; $display("[TB] FAIL multu_hi: got %h expected %h", hi, expHi); end
        checks++; if (lo !== expLo) begin errors++; $display("[TB] FAIL multu_lo: got %h expected %h", lo, expLo); end
        @(negedge clk);
        checks++; if (done !== 1'b0) begin errors++; $display("[TB] FAIL multu_done_width: got %b expected 0", done); end
        sel = SEL_MFHI; #1;
        checks++; if (dataout !== expHi) begin errors++; $display("[TB] FAIL mfhi_dataout: got %h expected %h", dataout, expHi); end
        sel = SEL_MFLO; #1;
        checks++; if (dataout !== expLo) begin errors++; $display("[TB] FAIL mflo_dataout: got %h expected %h", dataout, expLo); end
        sel = SEL_ADD; #1;
        checks++; if (dataout !== 32'd0) begin errors++; $display("[TB] FAIL other_dataout: got %h expected 0", dataout); end
    endtask

    task automatic test_divu();
        logic [31:0] xs [2] = '{32'd100, 32'd7};
        logic [31:0] ys [2] = '{32'd7, 32'd100};
        int dc, bc;
        for (int i = 0; i < 2; i++) begin
            startOp(SEL_DIVU, xs[i], ys[i]);
            observe(40, dc, bc);
            refModel(SEL_DIVU, xs[i], ys[i], expHi, expLo);
            checks++; if (dc !== 33) begin errors++; $display("[TB] FAIL divu_done_cycle[%0d]: got %0d expected 33", i, dc); end
            checks++; if (hi !== expHi) begin errors++; $display("[TB] FAIL divu_hi[%0d]: got %h expected %h", i, hi, expHi); end
            checks++; if (lo !== expLo) begin errors++; $display("[TB] FAIL divu_lo[%0d]: got %h expected %h", i, lo, expLo); end
        end
    endtask

    task automatic test_div_zero();
        int dc, bc;
        startOp(SEL_DIVU, 32'd5, 32'd0);
        observe(40, dc, bc);
        refModel(SEL_DIVU, 32'd5, 32'd0, expHi, expLo);
        checks++; if (dc !== 1) begin errors++; $display("[TB] FAIL divzero_done_cycle: got %0d expected 1", dc); end
        checks++; if (bc !== 0) begin errors++; $display("[TB] FAIL divzero_busy_cycles: got %0d expected 0", bc); end
        checks++; if (hi !== expHi) begin errors++; $display("[TB] FAIL divzero_hi: got %h expected %h", hi, expHi); end
        checks++; if (lo !== expLo) begin errors++; $display("[TB] FAIL divzero_lo: got %h expected %h", lo, expLo); end
        @(negedge clk);
        checks++; if (done !== 1'b0) begin errors++; $display("[TB] FAIL divzero_done_width: got %b expected 0", done); end
    endtask

    // Start requests during RUN and during DONE must be ignored; MFLO during
    // RUN still shows the previous LO.
    task automatic test_back_to_back();
        logic [31:0] prevLo;
        prevLo = expLo;
        startOp(SEL_MULTU, 32'd3, 32'd4);
        for (int c = 1; c <= 34; c++) begin
            if (c > 1) begin @(posedge clk); #1; end
            if (c == 10) begin start = 1'b1; sel = SEL_DIVU; a = 32'd9; b = 32'd3; end
            if (c == 11) begin start = 1'b0; sel = SEL_MFLO; end
            if (c == 33) begin start = 1'b1; sel = SEL_MULTU; a = 32'd1; b = 32'd1; end
            if (c == 34) start = 1'b0;
            @(negedge clk);
            checks++; if (busy !== (c <= 32)) begin errors++; $display("[TB] FAIL b2b_busy[c%0d]: got %b expected %b", c, busy, (c <= 32)); end
            checks++; if (done !== (c == 33)) begin errors++; $display("[TB] FAIL b2b_done[c%0d]: got %b expected %b", c, done, (c == 33)); end
            if (c >= 11 && c <= 32) begin
                checks++; if (dataout !== prevLo) begin errors++; $display("[TB] FAIL b2b_mflo_run[c%0d]: got %h expected %h", c, dataout, prevLo); end
            end
        end
        refModel(SEL_MULTU, 32'd3, 32'd4, expHi, expLo);
        checks++; if (hi !== expHi) begin errors++; $display("[TB] FAIL b2b_hi: got %h expected %h", hi, expHi); end
        checks++; if (lo !== expLo) begin errors++; $display("[TB] FAIL b2b_lo: got %h expected %h", lo, expLo); end
    endtask

    task automatic test_reset_abort();
        int dc, bc;
        startOp(SEL_MULTU, 32'h0001_0000, 32'h0001_0000);
        for (int c = 1; c <= 15; c++) begin
            if (c > 1) begin @(posedge clk); #1; end
            if (c == 14) begin
                @(negedge clk);
                checks++; if (lo !== expLo) begin errors++; $display("[TB] FAIL abort_lo_hold: got %h expected %h", lo, expLo); end
            end
            if (c == 15) reset = 1'b1;
        end
        @(posedge clk); #1 reset = 1'b0;
        @(negedge clk);
        expHi = '0; expLo = '0;
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL abort_busy: got %b expected 0", busy); end
        checks++; if (hi !== expHi) begin errors++; $display("[TB] FAIL abort_hi: got %h expected %h", hi, expHi); end
        checks++; if (lo !== expLo) begin errors++; $display("[TB] FAIL abort_lo: got %h expected %h", lo, expLo); end
        observe(40, dc, bc);
        checks++; if (dc !== -1) begin errors++; $display("[TB] FAIL abort_no_done: got done in cycle %0d expected none", dc); end
    endtask

    task automatic test_unsupported();
        logic [5:0] list [$] = '{SEL_MFHI, SEL_MFLO, SEL_ADD};
        int dc, bc;
`ifndef SIGNED_MULDIV_EN
        list.push_back(SEL_MULT);
        list.push_back(SEL_DIV);
`endif
        foreach (list[i]) begin
            startOp(list[i], $urandom, $urandom);
            observe(40, dc, bc);
            checks++; if (dc !== -1) begin errors++; $display("[TB] FAIL unsup_done[sel%0d]: got cycle %0d expected none", list[i], dc); end
            checks++; if (bc !== 0) begin errors++; $display("[TB] FAIL unsup_busy[sel%0d]: got %0d expected 0", list[i], bc); end
            checks++; if (lo !== expLo) begin errors++; $display("[TB] FAIL unsup_lo[sel%0d]: got %h expected %h", list[i], lo, expLo); end
        end
    endtask

    task automatic test_signed();
`ifdef SIGNED_MULDIV_EN
        logic [5:0]  ss [6] = '{SEL_MULT, SEL_DIV, SEL_DIV, SEL_DIV, SEL_DIV, SEL_MULT};
        logic [31:0] xs [6] = '{32'hFFFF_FFFD, 32'hFFFF_FFF9, 32'h8000_0000, 32'hFFFF_FFF7, 32'd9, 32'h8000_0000};
        logic [31:0] ys [6] = '{32'd5, 32'd2, 32'hFFFF_FFFF, 32'd0, 32'hFFFF_FFFC, 32'h8000_0000};
        int dc, bc, expDc;
        for (int i = 0; i < 6; i++) begin
            startOp(ss[i], xs[i], ys[i]);
            observe(40, dc, bc);
            refModel(ss[i], xs[i], ys[i], expHi, expLo);
            expDc = (ss[i] == SEL_DIV && ys[i] == 0) ? 1 : 33;
            checks++; if (dc !== expDc) begin errors++; $display("[TB] FAIL signed_done_cycle[%0d]: got %0d expected %0d", i, dc, expDc); end
            checks++; if (hi !== expHi) begin errors++; $display("[TB] FAIL signed_hi[%0d]: got %h expected %h", i, hi, expHi); end
            checks++; if (lo !== expLo) begin errors++; $display("[TB] FAIL signed_lo[%0d]: got %h expected %h", i, lo, expLo); end
        end
`endif
    endtask

    task automatic test_random();
        logic [5:0]  s;
        logic [31:0] x, y;
        int dc, bc, expDc, expBc, kinds;
`ifdef SIGNED_MULDIV_EN
        kinds = 4;
`else
        kinds = 2;
`endif
        for (int i = 0; i < 30; i++) begin
            case ($urandom_range(0, kinds - 1))
                0: s = SEL_MULTU;
                1: s = SEL_DIVU;
                2: s = SEL_MULT;
                default: s = SEL_DIV;
            endcase
            x = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 255)) : $urandom;
            y = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 15)) : $urandom;
            startOp(s, x, y);
            observe(40, dc, bc);
            refModel(s, x, y, expHi, expLo);
            expDc = ((s == SEL_DIVU || s == SEL_DIV) && y == 0) ? 1 : 33;
            expBc = (expDc == 1) ? 0 : 32;
            checks++; if (dc !== expDc) begin errors++; $display("[TB] FAIL rand_done_cycle[%0d]: got %0d expected %0d", i, dc, expDc); end
            checks++; if (bc !== expBc) begin errors++; $display("[TB] FAIL rand_busy_cycles[%0d]: got %0d expected %0d", i, bc, expBc); end
            checks++; if (hi !== expHi) begin errors++; $display("[TB] FAIL rand_hi[%0d] sel=%0d a=%h b=%h: got %h expected %h", i, s, x, y, hi, expHi); end
            checks++; if (lo !== expLo) begin errors++; $display("[TB] FAIL rand_lo[%0d] sel=%0d a=%h b=%h: got %h expected %h", i, s, x, y, lo, expLo); end
        end
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; sel = SEL_ADD; a = '0; b = '0;
        expHi = '0; expLo = '0;
        test_reset();
        test_multu();
        test_divu();
        test_div_zero();
        test_back_to_back();
        test_reset_abort();
        test_unsupported();
        test_signed();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/muldiv_hilo.md
Name: muldiv_hilo

Overview:
- Multi-cycle 32-bit multiply/divide unit in the execute stage, sitting beside ALU_32.
- Takes the same a/b operands and 6-bit funct code `sel`, and owns the HI/LO register pair.
- Its `dataout` (MFHI/MFLO) is muxed with ALU_32 `dataout` ahead of writeback.
- Sequential shift-add multiply and restoring divide; one bit per cycle.

Parameters:
- WIDTH, 32, operand and HI/LO width.
- CNT_W, 6, iteration counter width; must hold WIDTH.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- start  input  1  request; sampled only in IDLE.
- sel  input  6  funct code: MULTU 6'd25, DIVU 6'd27, MFHI 6'd16, MFLO 6'd18.
- a  input  WIDTH  multiplicand / dividend.
- b  input  WIDTH  multiplier / divisor.
- busy  output  1  operation in progress.
- done  output  1  one-cycle completion pulse.
- hi  output  WIDTH  HI register.
- lo  output  WIDTH  LO register.
- dataout  output  WIDTH  HI when sel==MFHI, LO when sel==MFLO, else 0 (combinational).

Behaviour:
- Reset (sync, high): state=IDLE; busy=0, done=0, hi=0, lo=0, counter=0; any in-flight operation is aborted.
- States: IDLE, RUN, DONE.
- IDLE:
  - start=1 with sel MULTU or DIVU: latch a, b and op at the edge; counter=0; go to RUN.
  - start=1 with any other sel: ignored, stay IDLE, no done.
- RUN: one iteration per edge; counter increments; after the 32nd iteration (counter==WIDTH-1) go to DONE and write hi/lo at that same edge.
- DONE: done=1 for exactly one cycle; go to IDLE at the next edge.
- Timing: start high in cycle 0 gives busy=1 in cycles 1..32, done=1 in cycle 33, back in IDLE in cycle 34. busy=0 in DONE.
- MULTU:
  - 64-bit product {hi,lo} = a*b, unsigned, computed by shift-add with accumulator {P[WIDTH:0], multiplier}.
  - Carry out of the adder is kept in the extra bit; no overflow is possible.
- DIVU:
  - Restoring division. lo = a / b, hi = a % b, unsigned.
  - Divide-by-zero (b==0 at accept): skip RUN, go directly to DONE. Write hi=a, lo=32'hFFFFFFFF. done appears in cycle 1.
- hi/lo change only at a completion edge or at reset. MFHI/MFLO during RUN return the previous values.
- start while busy or in DONE is ignored, and the operands are not relatched.
- a, b and sel may change freely after the accept edge; internal copies are used.

Optional Feature:
- Macro SIGNED_MULDIV_EN.
- Defined:
  - Adds MULT 6'd24 and DIV 6'd26.
  - Operands are converted to magnitudes at accept; the sign of the result is fixed by two's-complement negation at the completion write. Latency is unchanged.
  - DIV: quotient truncates toward zero; the remainder takes the sign of the dividend.
  - DIV by zero: hi=a, lo=32'hFFFFFFFF.
  - 0x80000000 / -1: lo=0x80000000, hi=0.
- Not defined: funct 24 and 26 are treated as unsupported and ignored in IDLE.

Decomposition:
- Package muldiv_pkg:
  - funct constants shared with ALU_32: ADD 32, SUB 34, AND 36, OR 37, SLT 42, MFHI 16, MFLO 18, MULT 24, MULTU 25, DIV 26, DIVU 27.
  - state encoding IDLE/RUN/DONE.
  - WIDTH default.
- Sub-module divu_step: combinational single restoring-division step (partial remainder, dividend bit in → next remainder, quotient bit).
- The multiply step stays inline in the top.

Test Plan:
- MULTU a=0xFFFFFFFF b=0xFFFFFFFF start in cycle 0 → busy in cycles 1-32; done in cycle 33; hi=0xFFFFFFFE, lo=0x00000001; then MFHI/MFLO dataout match.
- DIVU a=100 b=7 → done in cycle 33; lo=14, hi=2. Repeat with a=7 b=100 → lo=0, hi=7.
- DIVU a=5 b=0 → done in cycle 1; hi=5, lo=0xFFFFFFFF.
- MULTU 3*4 in flight; pulse start with DIVU 9/3 in cycle 10 → ignored; result hi=0, lo=12. MFLO during RUN returns the prior lo.
- Start MULTU 0x10000*0x10000; assert reset in cycle 15 → cycle 16 shows busy=0, hi=lo=0; no done for the aborted op.
- With SIGNED_MULDIV_EN:
  - MULT -3*5 → hi=0xFFFFFFFF, lo=0xFFFFFFF1.
  - DIV -7/2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF.
  - Without the macro, start with sel=24 → no done.
